// File: rtl/msgpass_buff_wr_arbiter_pkg.sv
// Shared configuration for the message-passing buffer and its write-side arbiter:
// buffer geometry, the queued write request type and the arbiter priority states.
package msgPass_config_pkg;

    localparam int MSGPASS_BUFF_ADDR_WIDTH  = 6;
    localparam int MSGPASS_BUFF_RDATA_WIDTH = 8;
    localparam int MSGPASS_WR_FIFO_DEPTH    = 4;

    // One queued buffer write at the default buffer geometry
    typedef struct packed {
        logic [MSGPASS_BUFF_ADDR_WIDTH-1:0]  addr;
        logic [MSGPASS_BUFF_RDATA_WIDTH-1:0] data;
    } msgPass_wr_req_t;

    // Which port wins the next same-address collision
    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } msgPass_arb_prio_e;

endpackage

// File: rtl/msgpass_buff_wr_arbiter_if.sv
// Producer-facing request handshakes and buffer-facing write ports of the write arbiter.
// The master side is the producer/buffer environment, the slave side is the arbiter.
interface msgpass_buff_wr_arbiter_if
    import msgPass_config_pkg::*;
#(
    parameter int ADDR_WIDTH = MSGPASS_BUFF_ADDR_WIDTH,
    parameter int DATA_WIDTH = MSGPASS_BUFF_RDATA_WIDTH,
    parameter int CNT_WIDTH  = 16
);

    logic                  req_valid_portA_i;
    logic                  req_valid_portB_i;
    logic                  req_ready_portA_o;
    logic                  req_ready_portB_o;
    logic [ADDR_WIDTH-1:0] req_addr_portA_i;
    logic [ADDR_WIDTH-1:0] req_addr_portB_i;
    logic [DATA_WIDTH-1:0] req_data_portA_i;
    logic [DATA_WIDTH-1:0] req_data_portB_i;

    logic                  wen_portA_o;
    logic                  wen_portB_o;
    logic [ADDR_WIDTH-1:0] waddr_portA_o;
    logic [ADDR_WIDTH-1:0] waddr_portB_o;
    logic [DATA_WIDTH-1:0] wdata_portA_o;
    logic [DATA_WIDTH-1:0] wdata_portB_o;

    logic [CNT_WIDTH-1:0]  collision_cnt_o;
    logic                  drained_o;

    modport master (
        output req_valid_portA_i, req_valid_portB_i,
        output req_addr_portA_i, req_addr_portB_i,
        output req_data_portA_i, req_data_portB_i,
        input  req_ready_portA_o, req_ready_portB_o,
        input  wen_portA_o, wen_portB_o,
        input  waddr_portA_o, waddr_portB_o,
        input  wdata_portA_o, wdata_portB_o,
        input  collision_cnt_o, drained_o
    );

    modport slave (
        input  req_valid_portA_i, req_valid_portB_i,
        input  req_addr_portA_i, req_addr_portB_i,
        input  req_data_portA_i, req_data_portB_i,
        output req_ready_portA_o, req_ready_portB_o,
        output wen_portA_o, wen_portB_o,
        output waddr_portA_o, waddr_portB_o,
        output wdata_portA_o, wdata_portB_o,
        output collision_cnt_o, drained_o
    );

endinterface

// File: rtl/msgpass_wr_fifo.sv
// Small synchronous request queue. Pointers carry one extra wrap bit so that
// full and empty are told apart without a separate occupancy counter.
module msgpass_wr_fifo
    import msgPass_config_pkg::*;
#(
    parameter int  DEPTH   = MSGPASS_WR_FIFO_DEPTH,
    parameter type entry_t = msgPass_wr_req_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign head  = mem_q[rd_ptr_q[IDX_W-1:0]];

    // Next pointers and storage: a push writes the tail slot, a pop advances the head
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[IDX_W-1:0]] = push_data;
            wr_ptr_d                   = wr_ptr_q + PTR_W'(1);
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    // Pointer registers; reset empties the queue immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: slots are only read after being written
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/msgpass_buff_wr_arbiter.sv
// Write-side arbiter in front of the dual-port message buffer. Each producer
// stream is queued; the issue stage never presents both buffer ports with the
// same address, serialising such collisions with alternating priority.
module msgpass_buff_wr_arbiter
    import msgPass_config_pkg::*;
#(
    parameter int ADDR_WIDTH = MSGPASS_BUFF_ADDR_WIDTH,
    parameter int DATA_WIDTH = MSGPASS_BUFF_RDATA_WIDTH,
    parameter int FIFO_DEPTH = MSGPASS_WR_FIFO_DEPTH,
    parameter int CNT_WIDTH  = 16
) (
    input logic                      write_clk_i,
    input logic                      rstn,
    msgpass_buff_wr_arbiter_if.slave bus
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } req_t;

    req_t              push_req_a, push_req_b;
    req_t              head_a, head_b;
    logic              full_a, full_b, empty_a, empty_b;
    logic              push_a, push_b;
    logic              issue_a, issue_b, collision;
    msgPass_arb_prio_e prio_q, prio_d;

    logic                  wen_a_q, wen_a_d, wen_b_q, wen_b_d;
    logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_a_d, waddr_b_q, waddr_b_d;
    logic [DATA_WIDTH-1:0] wdata_a_q, wdata_a_d, wdata_b_q, wdata_b_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    assign push_req_a = '{addr: bus.req_addr_portA_i, data: bus.req_data_portA_i};
    assign push_req_b = '{addr: bus.req_addr_portB_i, data: bus.req_data_portB_i};
    assign push_a     = bus.req_valid_portA_i & ~full_a;
    assign push_b     = bus.req_valid_portB_i & ~full_b;

    msgpass_wr_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(req_t)) u_fifo_a (
        .clk(write_clk_i), .rst_n(rstn), .push(push_a), .push_data(push_req_a),
        .pop(issue_a), .full(full_a), .empty(empty_a), .head(head_a)
    );

    msgpass_wr_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(req_t)) u_fifo_b (
        .clk(write_clk_i), .rst_n(rstn), .push(push_b), .push_data(push_req_b),
        .pop(issue_b), .full(full_b), .empty(empty_b), .head(head_b)
    );

    // Priority FSM next state and issue decision: on a same-address pair only the favoured port goes
    always_comb begin
        collision = ~empty_a & ~empty_b & (head_a.addr == head_b.addr);
        issue_a   = ~empty_a;
        issue_b   = ~empty_b;
        prio_d    = prio_q;
        if (collision) begin
            case (prio_q)
                PRIO_A: begin
                    issue_b = 1'b0;
                    prio_d  = PRIO_B;
                end
                PRIO_B: begin
                    issue_a = 1'b0;
                    prio_d  = PRIO_A;
                end
                default: prio_d = PRIO_A;
            endcase
        end
    end

    // Output register loads and saturating collision count; idle ports hold their last addr/data
    always_comb begin
        wen_a_d   = ~issue_a;
        wen_b_d   = ~issue_b;
        waddr_a_d = issue_a ? head_a.addr : waddr_a_q;
        wdata_a_d = issue_a ? head_a.data : wdata_a_q;
        waddr_b_d = issue_b ? head_b.addr : waddr_b_q;
        wdata_b_d = issue_b ? head_b.data : wdata_b_q;
        cnt_d     = cnt_q;
        if (collision && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    // State and output registers; reset withdraws any presented write at once
    always_ff @(posedge write_clk_i or negedge rstn) begin
        if (!rstn) begin
            prio_q    <= PRIO_A;
            wen_a_q   <= 1'b1;
            wen_b_q   <= 1'b1;
            waddr_a_q <= '0;
            waddr_b_q <= '0;
            wdata_a_q <= '0;
            wdata_b_q <= '0;
            cnt_q     <= '0;
        end else begin
            prio_q    <= prio_d;
            wen_a_q   <= wen_a_d;
            wen_b_q   <= wen_b_d;
            waddr_a_q <= waddr_a_d;
            waddr_b_q <= waddr_b_d;
            wdata_a_q <= wdata_a_d;
            wdata_b_q <= wdata_b_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.req_ready_portA_o = ~full_a;
    assign bus.req_ready_portB_o = ~full_b;
    assign bus.wen_portA_o       = wen_a_q;
    assign bus.wen_portB_o       = wen_b_q;
    assign bus.waddr_portA_o     = waddr_a_q;
    assign bus.waddr_portB_o     = waddr_b_q;
    assign bus.wdata_portA_o     = wdata_a_q;
    assign bus.wdata_portB_o     = wdata_b_q;
    assign bus.collision_cnt_o   = cnt_q;
    assign bus.drained_o         = empty_a & empty_b & wen_a_q & wen_b_q;

endmodule

// File: tb/tb_msgpass_buff_wr_arbiter.sv
// Bench for the write arbiter: directed scenarios plus a random phase, all
// compared cycle by cycle against a queue-based reference of the arbitration rules.
// A second instance with a 4-bit counter shares the stimulus to exercise saturation.
module tb_msgpass_buff_wr_arbiter;

    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rstn;
    logic          va, vb;
    logic [AW-1:0] aa, ab;
    logic [DW-1:0] da, db;

    msgpass_buff_wr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(16)) bus ();
    msgpass_buff_wr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(4))  bus4 ();

    assign bus.req_valid_portA_i  = va;
    assign bus.req_valid_portB_i  = vb;
    assign bus.req_addr_portA_i   = aa;
    assign bus.req_addr_portB_i   = ab;
    assign bus.req_data_portA_i   = da;
    assign bus.req_data_portB_i   = db;
    assign bus4.req_valid_portA_i = va;
    assign bus4.req_valid_portB_i = vb;
    assign bus4.req_addr_portA_i  = aa;
    assign bus4.req_addr_portB_i  = ab;
    assign bus4.req_data_portA_i  = da;
    assign bus4.req_data_portB_i  = db;

    msgpass_buff_wr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
        .write_clk_i(clk), .rstn(rstn), .bus(bus)
    );

    msgpass_buff_wr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(4)) dut4 (
        .write_clk_i(clk), .rstn(rstn), .bus(bus4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural buffer: captures whatever the arbiter presents on each port
    logic [DW-1:0] bufMem [2**AW];
    always @(posedge clk) begin
        if (bus.wen_portA_o == 1'b0) bufMem[bus.waddr_portA_o] <= bus.wdata_portA_o;
        if (bus.wen_portB_o == 1'b0) bufMem[bus.waddr_portB_o] <= bus.wdata_portB_o;
    end

    // Reference model: per-port request queues, a "B wins next" flag, collision tally
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    req_t          qa[$];
    req_t          qb[$];
    bit            nextB;
    int            collCnt;
    bit            expWenA, expWenB;
    logic [AW-1:0] expAddrA, expAddrB;
    logic [DW-1:0] expDataA, expDataB;

    int total = 0;
    int bad   = 0;
    bit sawReadyBLow;

    function automatic void modelReset();
        qa.delete();
        qb.delete();
        nextB    = 1'b0;
        collCnt  = 0;
        expWenA  = 1'b1;
        expWenB  = 1'b1;
        expAddrA = '0;
        expAddrB = '0;
        expDataA = '0;
        expDataB = '0;
    endfunction

    // One clock edge of the arbitration rules, using the inputs presented before the edge
    function automatic void modelEdge();
        bit   okA, okB, issA, issB;
        req_t r;
        okA  = (qa.size() < DEPTH);
        okB  = (qb.size() < DEPTH);
        issA = (qa.size() != 0);
        issB = (qb.size() != 0);
        if (issA && issB && (qa[0].addr == qb[0].addr)) begin
            if (nextB) issA = 1'b0;
            else       issB = 1'b0;
            nextB   = !nextB;
            collCnt = collCnt + 1;
        end
        expWenA = !issA;
        expWenB = !issB;
        if (issA) begin
            r        = qa.pop_front();
            expAddrA = r.addr;
            expDataA = r.data;
        end
        if (issB) begin
            r        = qb.pop_front();
            expAddrB = r.addr;
            expDataB = r.data;
        end
        if (va && okA) qa.push_back('{addr: aa, data: da});
        if (vb && okB) qb.push_back('{addr: ab, data: db});
    endfunction

    function automatic logic [31:0] sat(input int c, input int m);
        return (c > m) ? 32'(m) : 32'(c);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        bit expDrained;
        expDrained = (qa.size() == 0) && (qb.size() == 0) && expWenA && expWenB;
        check("wenA",     32'(bus.wen_portA_o),     32'(expWenA));
        check("wenB",     32'(bus.wen_portB_o),     32'(expWenB));
        check("waddrA",   32'(bus.waddr_portA_o),   32'(expAddrA));
        check("wdataA",   32'(bus.wdata_portA_o),   32'(expDataA));
        check("waddrB",   32'(bus.waddr_portB_o),   32'(expAddrB));
        check("wdataB",   32'(bus.wdata_portB_o),   32'(expDataB));
        check("readyA",   32'(bus.req_ready_portA_o), 32'(qa.size() < DEPTH));
        check("readyB",   32'(bus.req_ready_portB_o), 32'(qb.size() < DEPTH));
        check("drained",  32'(bus.drained_o),       32'(expDrained));
        check("collCnt",  32'(bus.collision_cnt_o), sat(collCnt, 65535));
        check("collCnt4", 32'(bus4.collision_cnt_o), sat(collCnt, 15));
        check("wen4A",    32'(bus4.wen_portA_o),    32'(expWenA));
        check("wen4B",    32'(bus4.wen_portB_o),    32'(expWenB));
        check("drained4", 32'(bus4.drained_o),      32'(expDrained));
        check("sameAddrWrite",
              32'((bus.wen_portA_o === 1'b0) && (bus.wen_portB_o === 1'b0) &&
                  (bus.waddr_portA_o === bus.waddr_portB_o)), 32'd0);
        if (bus.req_ready_portB_o === 1'b0) sawReadyBLow = 1'b1;
    endtask

    task automatic applyStimulus(input logic iva, input logic [AW-1:0] iaa, input logic [DW-1:0] ida,
                                 input logic ivb, input logic [AW-1:0] iab, input logic [DW-1:0] idb);
        va = iva; aa = iaa; da = ida;
        vb = ivb; ab = iab; db = idb;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Run idle cycles until the reference has nothing left, bounded
    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if ((qa.size() == 0) && (qb.size() == 0) && expWenA && expWenB) break;
            idle();
        end
        check("drainDone", 32'(bus.drained_o), 32'd1);
    endtask

    // Both producers hold their request until accepted, streaming to fixed addresses
    task automatic stream(input int cycles, input logic [AW-1:0] addrA, input logic [AW-1:0] addrB,
                          input logic [DW-1:0] baseA, input logic [DW-1:0] baseB);
        logic [DW-1:0] nA, nB;
        bit            accA, accB;
        nA = baseA;
        nB = baseB;
        for (int i = 0; i < cycles; i++) begin
            accA = (qa.size() < DEPTH);
            accB = (qb.size() < DEPTH);
            applyStimulus(1'b1, addrA, nA, 1'b1, addrB, nB);
            if (accA) nA = nA + 8'd1;
            if (accB) nB = nB + 8'd1;
        end
    endtask

    initial begin
        rstn = 1'b1;
        va = 1'b0; vb = 1'b0;
        aa = '0;   ab = '0;
        da = '0;   db = '0;
        sawReadyBLow = 1'b0;

        $display("[TB] reset");
        #2 rstn = 1'b0;
        #1;
        modelReset();
        checkOutput();
        #9 rstn = 1'b1;

        $display("[TB] single write on port A");
        applyStimulus(1'b1, 6'd5, 8'hAA, 1'b0, '0, '0);
        idle();
        check("singleWenA", 32'(bus.wen_portA_o), 32'd0);
        check("singleAddrA", 32'(bus.waddr_portA_o), 32'd5);
        drain();
        check("bufAddr5", 32'(bufMem[5]), 32'hAA);

        $display("[TB] simultaneous writes to different addresses");
        applyStimulus(1'b1, 6'd3, 8'h11, 1'b1, 6'd7, 8'h22);
        idle();
        check("bothWenA", 32'(bus.wen_portA_o), 32'd0);
        check("bothWenB", 32'(bus.wen_portB_o), 32'd0);
        drain();
        check("bufAddr3", 32'(bufMem[3]), 32'h11);
        check("bufAddr7", 32'(bufMem[7]), 32'h22);
        check("noCollYet", 32'(bus.collision_cnt_o), 32'd0);

        $display("[TB] collision on address 9");
        applyStimulus(1'b1, 6'd9, 8'h11, 1'b1, 6'd9, 8'h22);
        idle();
        check("collK1WenA", 32'(bus.wen_portA_o), 32'd0);
        check("collK1WenB", 32'(bus.wen_portB_o), 32'd1);
        idle();
        check("collK2WenA", 32'(bus.wen_portA_o), 32'd1);
        check("collK2WenB", 32'(bus.wen_portB_o), 32'd0);
        drain();
        check("bufAddr9", 32'(bufMem[9]), 32'h22);
        check("collOne", 32'(bus.collision_cnt_o), 32'd1);

        $display("[TB] backpressure on a shared address");
        stream(12, 6'd12, 6'd12, 8'h40, 8'h80);
        check("readyBDropped", 32'(sawReadyBLow), 32'd1);
        drain();

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), DW'($urandom),
                          1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), DW'($urandom));
        end

        $display("[TB] reset mid-burst");
        applyStimulus(1'b1, 6'd20, 8'h5A, 1'b1, 6'd21, 8'hA5);
        applyStimulus(1'b1, 6'd22, 8'h5B, 1'b1, 6'd23, 8'hA6);
        #3;
        rstn = 1'b0;
        va = 1'b0;
        vb = 1'b0;
        #1;
        modelReset();
        checkOutput();
        @(posedge clk);
        #1;
        checkOutput();
        #2 rstn = 1'b1;
        idle();

        $display("[TB] counter saturation");
        stream(44, 6'd2, 6'd2, 8'h00, 8'h80);
        drain();
        check("sat4", 32'(bus4.collision_cnt_o), 32'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
